aes_ctr_datapath: RTL and testbench

Holds the full CTR-mode counter register for the AES cipher path and serves it slice-by-slice to the counter-increment FSM. Upstream control loads the IV and requests increments through a request/acknowledge handshake. This block sequences the FSM's `incr`/`ready` handshake, writes back the incremented slices, and exposes the whole counter to the cipher core. It sits between the AES control/IV registers and the slice-serial counter FSM.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_ctr_datapath.sv | 94 +++++++++
 tb/tb_aes_ctr_datapath.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES CTR types, slice geometry and sparse counter-FSM state encodings.
package aes_pkg;
    localparam int CtrWidthDef   = 128;
    localparam int SliceSizeCtr  = 16;
    localparam int NumSlicesDef  = CtrWidthDef / SliceSizeCtr;
    localparam int SliceIdxWidth = $clog2(NumSlicesDef);

    typedef logic [SliceSizeCtr-1:0]  ctr_slice_t;
    typedef logic [SliceIdxWidth-1:0] ctr_slice_idx_t;

    // Pairwise Hamming distance of 4 so a single upset never lands on another valid state.
    typedef enum logic [5:0] {
        CTR_IDLE  = 6'b001011,
        CTR_REQ   = 6'b110001,
        CTR_BUSY  = 6'b011100,
        CTR_ERROR = 6'b100110
    } ctr_state_e;
endpackage

// File: rtl/aes_ctr_datapath.sv
// aes_ctr_datapath: CTR counter register served slice-serially to the increment FSM.
// Optional sticky wrap detection is enabled by defining AES_CTR_WRAP_DETECT_EN.
module aes_ctr_datapath
    import aes_pkg::*;
#(
    parameter int CtrWidth = CtrWidthDef
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 iv_load_i,
    input  logic [CtrWidth-1:0]  iv_i,
    input  logic                 incr_req_i,
    output logic                 incr_ack_o,
    output logic [CtrWidth-1:0]  ctr_o,
    output logic                 incr_o,
    input  logic                 ready_i,
    input  ctr_slice_idx_t       ctr_slice_idx_i,
    output ctr_slice_t           ctr_slice_o,
    input  ctr_slice_t           ctr_slice_i,
    input  logic                 ctr_we_i,
    input  logic                 fsm_alert_i,
    output logic                 alert_o,
    output logic                 wrap_o
);
    localparam int NumSlices = CtrWidth / SliceSizeCtr;

    ctr_state_e          state_q, state_d;
    logic [CtrWidth-1:0] ctr_q, ctr_d, ctr_w;
    logic                first_q, err, load_en, wr_en, idx_oob;

    assign idx_oob = int'(ctr_slice_idx_i) >= NumSlices;
    assign err     = fsm_alert_i || (ctr_we_i && (state_q != CTR_BUSY || idx_oob));
    assign load_en = !err && state_q == CTR_IDLE && iv_load_i;
    assign wr_en   = !err && state_q == CTR_BUSY && ctr_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CTR_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= state_q == CTR_REQ;
        end
    end

    always_comb begin
        state_d = CTR_ERROR;
        case (state_q)
            CTR_IDLE:  state_d = (!iv_load_i && incr_req_i && ready_i) ? CTR_REQ : CTR_IDLE;
            CTR_REQ:   state_d = CTR_BUSY;
            CTR_BUSY:  state_d = (ready_i && !first_q) ? CTR_IDLE : CTR_BUSY;
            default:   state_d = CTR_ERROR;
        endcase
        state_d = err ? CTR_ERROR : state_d;
    end

    always_comb begin
        incr_o     = !err && state_q == CTR_REQ;
        incr_ack_o = !err && state_q == CTR_BUSY && ready_i && !first_q;
        alert_o    = state_q == CTR_ERROR;
    end

    always_comb begin
        ctr_w = ctr_q;
        ctr_w[int'(ctr_slice_idx_i)*SliceSizeCtr +: SliceSizeCtr] = ctr_slice_i;
    end

    assign ctr_d = load_en ? iv_i : wr_en ? ctr_w : ctr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ctr_q <= '0;
        else         ctr_q <= ctr_d;
    end

    assign ctr_o       = ctr_q;
    assign ctr_slice_o = ctr_q[int'(ctr_slice_idx_i)*SliceSizeCtr +: SliceSizeCtr];

`ifdef AES_CTR_WRAP_DETECT_EN
    logic wrap_q, wrap_d;
    // Wrap is only judged on the top slice write, when the whole carry chain has resolved.
    assign wrap_d = load_en ? 1'b0
                  : (wr_en && int'(ctr_slice_idx_i) == NumSlices-1 && ctr_w == '0) ? 1'b1
                  : wrap_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wrap_q <= 1'b0;
        else         wrap_q <= wrap_d;
    end

    assign wrap_o = wrap_q;
`else
    assign wrap_o = 1'b0;
`endif
endmodule

// File: tb/tb_aes_ctr_datapath.sv
// tb_aes_ctr_datapath: scoreboard bench with a behavioural slice-increment FSM.
module tb_aes_ctr_datapath;
    import aes_pkg::*;

`ifdef AES_CTR_WRAP_DETECT_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           iv_load = 1'b0, incr_req = 1'b0, ready = 1'b0;
    logic           ctr_we = 1'b0, fsm_alert = 1'b0;
    logic [127:0]   iv = '0;
    ctr_slice_idx_t ctr_slice_idx = '0;
    ctr_slice_t     ctr_slice_in = '0;
    logic           incr_ack_o, incr_o, alert_o, wrap_o;
    logic [127:0]   ctr_o;
    ctr_slice_t     ctr_slice_o;

    int             n_tests = 0, n_fail = 0;
    logic [127:0]   exp_q[$];
    logic [127:0]   ctr_m = '0;
    logic           wrap_m = 1'b0;

    aes_ctr_datapath dut (
        .clk_i(clk), .rst_ni(rst_n), .iv_load_i(iv_load), .iv_i(iv),
        .incr_req_i(incr_req), .incr_ack_o(incr_ack_o), .ctr_o(ctr_o), .incr_o(incr_o),
        .ready_i(ready), .ctr_slice_idx_i(ctr_slice_idx), .ctr_slice_o(ctr_slice_o),
        .ctr_slice_i(ctr_slice_in), .ctr_we_i(ctr_we), .fsm_alert_i(fsm_alert),
        .alert_o(alert_o), .wrap_o(wrap_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [127:0] act);
        logic [127:0] e;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        check(tag, act, e);
    endtask

    task automatic load(input logic [127:0] v);
        @(negedge clk);
        iv_load = 1'b1; iv = v;
        exp_q.push_back(v);
        @(negedge clk);
        iv_load = 1'b0;
        pop_check("load", ctr_o);
        ctr_m = v; wrap_m = 1'b0;
        check("load_wrap", wrap_o, 1'b0);
    endtask

    // alert_at >= 0 injects fsm_alert_i in that BUSY cycle instead of the slice write.
    task automatic do_incr(input logic ld, input logic [127:0] v, input int alert_at);
        logic [127:0] old, nw, frz;
        logic [16:0]  sum;
        logic         c;
        @(negedge clk);
        incr_req = 1'b1; ready = 1'b1;
        if (ld) begin
            iv_load = 1'b1; iv = v;
            exp_q.push_back(v);
            #1 check("ld_no_incr", incr_o, 1'b0);
            @(negedge clk);
            iv_load = 1'b0;
            pop_check("ld_req_ctr", ctr_o);
            ctr_m = v; wrap_m = 1'b0;
        end
        old = ctr_m; nw = old + 128'd1; frz = old;
        for (int j = 0; j < alert_at && j < 8; j++) frz[j*16 +: 16] = nw[j*16 +: 16];
        exp_q.push_back(alert_at < 0 ? nw : frz);
        #1 check("idle_incr", incr_o, 1'b0);
        @(negedge clk);
        incr_req = 1'b0; ready = 1'b0;
        check("incr", incr_o, 1'b1);
        c = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ctr_slice_idx = 3'(k);
            ready = (k == 0 || k == 7);
            fsm_alert = (k == alert_at);
            ctr_we = (k != alert_at);
            #1;
            if (alert_at < 0 || k < alert_at) check("slice_o", ctr_slice_o, old[k*16 +: 16]);
            sum = {1'b0, ctr_slice_o} + {16'd0, c};
            ctr_slice_in = sum[15:0]; c = sum[16];
            check("busy_incr", incr_o, 1'b0);
            check("ack", incr_ack_o, k == 7 && alert_at < 0);
            if (alert_at >= 0 && k > alert_at) check("alert", alert_o, 1'b1);
        end
        @(negedge clk);
        ctr_we = 1'b0; fsm_alert = 1'b0; ready = 1'b1;
        check("ack_done", incr_ack_o, 1'b0);
        pop_check("ctr", ctr_o);
        if (alert_at < 0) begin
            ctr_m = nw;
            if (nw == '0) wrap_m = 1'b1;
        end else ctr_m = frz;
        check("wrap", wrap_o, WrapEn && wrap_m);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ctr", ctr_o, '0);
        check("rst_incr", incr_o, 1'b0);
        check("rst_ack", incr_ack_o, 1'b0);
        check("rst_alert", alert_o, 1'b0);
        check("rst_wrap", wrap_o, 1'b0);
        check("rst_slice", ctr_slice_o, '0);
        rst_n = 1'b1;

        do_incr(1'b1, 128'd0, -1);
        do_incr(1'b1, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, -1);
        check("carry_full", ctr_o, 128'h1_0000_0000);
        ctr_slice_idx = 3'd2;
        #1 check("carry_s2", ctr_slice_o, 16'd1);
        ctr_slice_idx = 3'd1;
        #1 check("carry_s1", ctr_slice_o, 16'd0);
        do_incr(1'b0, '0, -1);
        do_incr(1'b1, {128{1'b1}}, -1);
        check("wrap_zero", ctr_o, '0);
        load(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        do_incr(1'b0, '0, -1);

        do_incr(1'b1, 128'h0000_1111_2222_3333_4444_5555_6666_FFFF, 2);
        incr_req = 1'b1; ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("err_incr", incr_o, 1'b0);
            check("err_alert", alert_o, 1'b1);
            check("err_frozen", ctr_o, ctr_m);
        end
        incr_req = 1'b0;
        rst_n = 1'b0;
        #1 check("rst_clr_alert", alert_o, 1'b0);
        check("rst_clr_ctr", ctr_o, '0);
        @(negedge clk);
        rst_n = 1'b1;

        load(128'hCAFE_0000_BEEF_0000_DEAD_0000_F00D_0001);
        @(negedge clk);
        ctr_we = 1'b1; ctr_slice_idx = 3'd3; ctr_slice_in = 16'hAAAA;
        @(negedge clk);
        ctr_we = 1'b0;
        check("idle_we_alert", alert_o, 1'b1);
        check("idle_we_ctr", ctr_o, ctr_m);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
